// File: rtl/psp_burst_ctrl_if.sv
// Control and byte-stream bundle for psp_burst_ctrl.
// slave  : the burst controller's view (takes control, drives status and bytes).
// master : the register block / sink view (drives control and byte_ready).
// Optional macro PSP_BURST_CTRL_ERRINJ_EN adds the err_inj control line.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high. byte_valid, once high, stays high with
// byte_data stable until that transfer happens or the burst is aborted.
// byte_ready may be driven freely and has no effect while byte_valid is low.
interface psp_burst_ctrl_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic             seed_load;
  logic [7:0]       seed;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             done;
  logic             bit_out;
  logic             bit_valid;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_ready;
`ifdef PSP_BURST_CTRL_ERRINJ_EN
  logic             err_inj;

  modport master (
    output start, seed_load, seed, len, abort, byte_ready, err_inj,
    input  busy, done, bit_out, bit_valid, byte_data, byte_valid
  );

  modport slave (
    input  start, seed_load, seed, len, abort, byte_ready, err_inj,
    output busy, done, bit_out, bit_valid, byte_data, byte_valid
  );
`else
  modport master (
    output start, seed_load, seed, len, abort, byte_ready,
    input  busy, done, bit_out, bit_valid, byte_data, byte_valid
  );

  modport slave (
    input  start, seed_load, seed, len, abort, byte_ready,
    output busy, done, bit_out, bit_valid, byte_data, byte_valid
  );
`endif
endinterface

// File: rtl/psp_burst_ctrl.sv
// psp_burst_ctrl: burst sequencer around the 8-bit PSP generator
// (x^8+x^4+x^3+x^2+1, period 255). A burst loads an optional seed, emits
// len*8 sequence bits (one per RUN cycle) and packs them MSB-first into
// bytes that are offered to the sink; backpressure stalls the generator.
// Optional macro PSP_BURST_CTRL_ERRINJ_EN adds bus.err_inj, which flips the
// emitted/packed bit of a RUN cycle without disturbing the generator.
// state_dbg and gen_dbg expose the FSM state and generator register.
module psp_burst_ctrl #(
  parameter logic [7:0] SEED_DEFAULT = 8'hB4,
  parameter int         LEN_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  psp_burst_ctrl_if.slave      bus,
  output logic [1:0]           state_dbg,
  output logic [7:0]           gen_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [7:0]       gen_q;
  logic [7:0]       gen_step;
  logic [7:0]       seed_eff;
  logic [LEN_W-1:0] remaining_q;
  logic [2:0]       bit_cnt_q;
  logic [6:0]       shreg_q;
  logic [7:0]       byte_q;

  logic             start_acc;
  logic             run_cyc;
  logic             byte_acc;
  logic             last_bit;
  logic             inj;
  logic             bit_w;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    run_cyc   = 1'b0;
    byte_acc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          start_acc = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        // The generator steps on every RUN cycle, the abort cycle included,
        // so a later burst resumes right after the last emitted bit.
        run_cyc = 1'b1;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q == 3'd7) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Abort has priority over a simultaneous accept.
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.byte_ready) begin
          byte_acc = 1'b1;
          state_d  = (remaining_q == LEN_W'(1)) ? S_DONE : S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // One generator step: shift towards s7, feed s7 back into s0, s2, s3, s4.
  assign gen_step = {gen_q[6], gen_q[5], gen_q[4],
                     gen_q[3] ^ gen_q[7],
                     gen_q[2] ^ gen_q[7],
                     gen_q[1] ^ gen_q[7],
                     gen_q[0], gen_q[7]};

  // A zero seed would lock the generator at zero, so it maps to the default.
  assign seed_eff = (bus.seed == 8'h00) ? SEED_DEFAULT : bus.seed;

`ifdef PSP_BURST_CTRL_ERRINJ_EN
  assign inj = bus.err_inj & run_cyc;
`else
  assign inj = 1'b0;
`endif

  assign bit_w    = gen_q[7] ^ inj;
  assign last_bit = run_cyc && (bit_cnt_q == 3'd7);

  // Generator register: seeded on an accepted start, stepped in RUN, else held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_q <= SEED_DEFAULT;
    end else if (start_acc) begin
      if (bus.seed_load) begin
        gen_q <= seed_eff;
      end
    end else if (run_cyc) begin
      gen_q <= gen_step;
    end
  end

  // Byte and bit bookkeeping for the running burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      bit_cnt_q   <= 3'd0;
    end else if (start_acc) begin
      remaining_q <= bus.len;
      bit_cnt_q   <= 3'd0;
    end else if (byte_acc) begin
      remaining_q <= remaining_q - LEN_W'(1);
      bit_cnt_q   <= 3'd0;
    end else if (run_cyc) begin
      bit_cnt_q   <= bit_cnt_q + 3'd1;
    end
  end

  // MSB-first packing; the finished byte is captured on the 8th bit and
  // then held until the next byte completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= 7'd0;
      byte_q  <= 8'h00;
    end else if (start_acc) begin
      shreg_q <= 7'd0;
    end else if (run_cyc) begin
      shreg_q <= {shreg_q[5:0], bit_w};
      if (last_bit) begin
        byte_q <= {shreg_q, bit_w};
      end
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.bit_valid  = (state_q == S_RUN);
  assign bus.byte_valid = (state_q == S_HOLD);
  assign bus.bit_out    = bit_w;
  assign bus.byte_data  = byte_q;

  assign state_dbg = state_q;
  assign gen_dbg   = gen_q;

endmodule

// File: tb/tb_psp_burst_ctrl.sv
// Testbench for psp_burst_ctrl: table of burst records plus hand-written
// sequences (len==0, mid-burst reset, optional error injection). A bit and
// byte scoreboard is filled from an independent generator model.
`timescale 1ns/1ps
module tb_psp_burst_ctrl;
  localparam int LEN_W  = 16;
  localparam int BUDGET = 300;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  logic [7:0] gen_dbg;

  psp_burst_ctrl_if #(.LEN_W(LEN_W)) bus();

  psp_burst_ctrl #(.SEED_DEFAULT(8'hB4), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg),
    .gen_dbg   (gen_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int         n_cmp    = 0;
  int         n_bad    = 0;
  int         done_cnt = 0;
  logic       prev_done;
  logic [7:0] m_gen;
  logic [7:0] exp_q[$];
  logic       exp_bit_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  // Reference generator: multiply by x modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] m_step(logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
  endfunction

  task automatic push_model(input int n_bits, input int n_bytes, input logic inv_first);
    logic [7:0] acc;
    logic       b;
    acc = 8'h00;
    for (int i = 0; i < n_bits; i++) begin
      b = m_gen[7] ^ (inv_first && (i == 0));
      exp_bit_q.push_back(b);
      acc   = {acc[6:0], b};
      m_gen = m_step(m_gen);
      if ((i % 8 == 7) && (i / 8 < n_bytes)) exp_q.push_back(acc);
    end
  endtask

  // Monitor: every emitted bit and every accepted byte is checked.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (bus.bit_valid) begin
        if (exp_bit_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL bit_extra: got bit %0b, required no bit", bus.bit_out);
        end else begin
          chk("bit_out", bus.bit_out, exp_bit_q.pop_front());
        end
      end
      if (bus.byte_valid && bus.byte_ready && !bus.abort) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL byte_extra: got 0x%0h, required no byte", bus.byte_data);
        end else begin
          chk("byte_data", bus.byte_data, exp_q.pop_front());
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_width", prev_done, 1'b0);
      end
      prev_done = bus.done;
    end
  end

  // ---------------- vectors ----------------
  // mode: 0 normal, 1 abort at RUN bit index abit, 2 abort+ready in first
  // HOLD, 3 abort during DONE.
  typedef struct packed {
    logic        sl;
    logic [7:0]  seed;
    logic [15:0] len;
    int          stall;
    int          mode;
    int          abit;
    logic        poke;
    logic        inj;
    logic [7:0]  exp_byte;
    logic        chk_byte;
    logic [7:0]  exp_gen;
    logic        chk_gen;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic drive_idle();
    bus.start      = 1'b0;
    bus.seed_load  = 1'b0;
    bus.seed       = 8'h00;
    bus.len        = '0;
    bus.abort      = 1'b0;
    bus.byte_ready = 1'b0;
`ifdef PSP_BURST_CTRL_ERRINJ_EN
    bus.err_inj    = 1'b0;
`endif
  endtask

  task automatic run_burst(input vec_t v);
    int         cyc, bit_idx, hold_n, first_hold, done_cyc, done0, n_bits, n_bytes;
    logic [7:0] first_byte;
    logic       got_byte;
    logic       normal;
    normal  = (v.mode == 0) || (v.mode == 3);
    done0   = done_cnt;
    if (v.sl) m_gen = (v.seed == 8'h00) ? 8'hB4 : v.seed;
    n_bits  = (v.mode == 1) ? v.abit + 1 : (v.mode == 2) ? 8 : 8 * int'(v.len);
    n_bytes = normal ? int'(v.len) : 0;
    push_model(n_bits, n_bytes, v.inj);

    bus.start     = 1'b1;
    bus.seed_load = v.sl;
    bus.seed      = v.seed;
    bus.len       = v.len;
    @(posedge clk); #1;
    cyc = 0; bit_idx = 0; hold_n = 0; first_hold = -1; done_cyc = -1;
    got_byte = 1'b0; first_byte = 8'h00;
    while (bus.busy && cyc < BUDGET) begin
      drive_idle();
      if (bus.bit_valid) begin
        if (v.mode == 1 && bit_idx == v.abit) bus.abort = 1'b1;
`ifdef PSP_BURST_CTRL_ERRINJ_EN
        if (v.inj && bit_idx == 0) bus.err_inj = 1'b1;
`endif
        bit_idx++;
      end
      if (bus.byte_valid) begin
        if (first_hold < 0) begin
          first_hold = cyc;
          first_byte = bus.byte_data;
          got_byte   = 1'b1;
        end
        if (v.mode == 2) begin
          bus.abort      = 1'b1;
          bus.byte_ready = 1'b1;
        end else if (hold_n < v.stall) begin
          chk("hold_data", bus.byte_data, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
          chk("hold_no_bit", bus.bit_valid, 1'b0);
          chk("hold_busy", bus.busy, 1'b1);
          hold_n++;
        end else begin
          bus.byte_ready = 1'b1;
          hold_n = 0;
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        if (v.mode == 3) bus.abort = 1'b1;
      end
      if (v.poke && cyc == 3) begin
        bus.start     = 1'b1;
        bus.seed_load = 1'b1;
        bus.seed      = 8'h77;
        bus.len       = 16'd5;
      end
      @(posedge clk); #1;
      cyc++;
    end
    drive_idle();

    chk("burst_end_in_budget", (cyc < BUDGET), 1'b1);
    chk("idle_after", state_dbg, 2'd0);
    chk("busy_after", bus.busy, 1'b0);
    chk("done_count", done_cnt - done0, normal ? 1 : 0);
    if (normal) begin
      chk("byte_valid_edge", first_hold, 8);
      chk("done_cycle", done_cyc, (9 + v.stall) * int'(v.len));
      if (v.chk_byte) chk("first_byte", first_byte, v.exp_byte);
    end else if (v.mode == 1) begin
      chk("abort_no_byte", got_byte, 1'b0);
    end
    chk("gen_model", gen_dbg, m_gen);
    if (v.chk_gen) chk("gen_const", gen_dbg, v.exp_gen);
    chk("bits_left", exp_bit_q.size(), 0);
    chk("bytes_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   done0;
    vec_t v;
    //            sl    seed   len    stall mode abit poke  inj   exp_b  chk   exp_g  chk
    vecs[0] = '{1'b1, 8'hB4, 16'd1, 0,    0,   0,   1'b0, 1'b0, 8'hB8, 1'b1, 8'h18, 1'b1};
    vecs[1] = '{1'b1, 8'hB4, 16'd1, 5,    0,   0,   1'b0, 1'b0, 8'hB8, 1'b1, 8'h18, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 16'd3, 2,    0,   0,   1'b1, 1'b0, 8'h19, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 16'd1, 0,    0,   0,   1'b0, 1'b0, 8'hB8, 1'b1, 8'h18, 1'b1};
    vecs[4] = '{1'b1, 8'hB4, 16'd2, 0,    1,   4,   1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 16'd1, 0,    0,   0,   1'b0, 1'b0, 8'h03, 1'b1, 8'h27, 1'b1};
    vecs[6] = '{1'b1, 8'hB4, 16'd2, 0,    2,   0,   1'b0, 1'b0, 8'h00, 1'b0, 8'h18, 1'b1};
    vecs[7] = '{1'b1, 8'h5A, 16'd2, 1,    0,   0,   1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[8] = '{1'b1, 8'hB4, 16'd1, 0,    3,   0,   1'b0, 1'b0, 8'hB8, 1'b1, 8'h18, 1'b1};

    rst_n = 1'b0;
    drive_idle();
    m_gen = 8'hB4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state_dbg, 2'd0);
    chk("rst_gen", gen_dbg, 8'hB4);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_bit_valid", bus.bit_valid, 1'b0);
    chk("rst_byte_valid", bus.byte_valid, 1'b0);
    chk("rst_byte_data", bus.byte_data, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].stall == 0 && i == 7) vecs[i].stall = $urandom_range(1, 3);
      run_burst(vecs[i]);
    end

    // len==0 is ignored: no seed load, no busy, no done.
    done0 = done_cnt;
    bus.start     = 1'b1;
    bus.seed_load = 1'b1;
    bus.seed      = 8'h11;
    bus.len       = '0;
    @(posedge clk); #1;
    drive_idle();
    repeat (3) begin
      chk("len0_busy", bus.busy, 1'b0);
      @(posedge clk); #1;
    end
    chk("len0_done", done_cnt - done0, 0);
    chk("len0_gen", gen_dbg, m_gen);

`ifdef PSP_BURST_CTRL_ERRINJ_EN
    v = '{1'b1, 8'hB4, 16'd1, 0, 0, 0, 1'b0, 1'b1, 8'h38, 1'b1, 8'h18, 1'b1};
    run_burst(v);
`endif

    // Reset in the middle of a burst: three bits out, then back to reset values.
    v = '{1'b1, 8'h5A, 16'd1, 0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    m_gen = v.seed;
    push_model(3, 0, 1'b0);
    bus.start     = 1'b1;
    bus.seed_load = 1'b1;
    bus.seed      = v.seed;
    bus.len       = v.len;
    @(posedge clk); #1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", state_dbg, 2'd0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_bit_valid", bus.bit_valid, 1'b0);
    chk("mid_rst_gen", gen_dbg, 8'hB4);
    chk("mid_rst_byte_data", bus.byte_data, 8'h00);
    chk("mid_rst_bits_left", exp_bit_q.size(), 0);
    m_gen = 8'hB4;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh burst after reset continues from the default seed.
    v = '{1'b0, 8'h00, 16'd1, 0, 0, 0, 1'b0, 1'b0, 8'hB8, 1'b1, 8'h18, 1'b1};
    run_burst(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
